multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle control unit for the CPU datapath. A state machine steps each instruction through IF/ID/EXE/MEM/WB from the 6-bit opcode and ALU flags. It sits directly upstream of the program counter: it generates `PCWre` and `PCSrc`, which tell the PC when to latch and which next-PC source to use. It also drives the datapath enables (IR, register file, data memory, muxes, ALU op).

## Interface
- Parameters: none. Opcode, state and code constants come from `cpu_pkg`.
- Reset: one clock; reset is asynchronous and active-high.
- `CLK` in 1 — system clock. State register updates on the rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `opcode` in 6 — IR[31:26]. Sampled in ID and held stable by the IR thereafter.
- `zero` in 1 — ALU result == 0.
- `sign` in 1 — ALU result[31].
- `PCWre` out 1 — PC write enable.
- `PCSrc` out 2 — next-PC source: 00 PC+4, 01 branch, 10 jr (ReadData1), 11 jump.
- `IRWre` out 1 — instruction register write.
- `RegWre` out 1 — register-file write.
- `RegDst` out 2 — destination register: 00 $31, 01 rt, 10 rd.
- `WrRegDSrc` out 1 — 0 writes PC+4 (jal), 1 writes DB.
- `ALUSrcA` out 1 — 1 selects sa (shift amount).
- `ALUSrcB` out 1 — 1 selects the extended immediate.
- `ExtSel` out 1 — 1 sign-extend, 0 zero-extend.
- `ALUOp` out 3 — 000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed).
- `mRD` out 1 — data memory read.
- `mWR` out 1 — data memory write.
- `DBDataSrc` out 1 — 1 selects memory data onto DB.

## Operation
- Opcodes:
  - R/I ALU: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, sll 011000, slt 100110, slti 100111.
  - Memory: sw 110000, lw 110001.
  - Branch: beq 110100, bne 110101, bltz 110110.
  - Jump: j 111000, jr 111001, jal 111010.
  - halt 111111. Any other opcode is treated as halt.
- States: sIF, sID, sEXE_AL, sEXE_BR, sEXE_LS, sMEM, sWB_AL, sWB_LD, sHALT.
- Transitions:
  - sIF→sID always.
  - From sID:
    - j/jr/jal → sIF.
    - Branches → sEXE_BR.
    - lw/sw → sEXE_LS.
    - ALU ops → sEXE_AL.
    - halt → sHALT.
  - sEXE_AL→sWB_AL→sIF.
  - sEXE_BR→sIF.
  - sEXE_LS→sMEM.
  - sMEM: lw → sWB_LD, sw → sIF.
  - sWB_LD→sIF.
  - sHALT is held until `RST`.
- Outputs are combinational from (state, opcode, zero, sign). Every enable is 0 unless listed below.
  - sIF: `IRWre`=1.
  - sID (jumps only): `PCWre`=1; `PCSrc`=11 for j/jal, 10 for jr. For jal also `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0.
  - sEXE_BR: `PCWre`=1, `ALUOp`=001.
    - beq: `PCSrc`=01 iff zero=1.
    - bne: `PCSrc`=01 iff zero=0.
    - bltz: `PCSrc`=01 iff sign=1.
    - Otherwise `PCSrc`=00.
  - sMEM: `mRD`=1 for lw. For sw: `mWR`=1, `PCWre`=1, `PCSrc`=00.
  - sWB_AL / sWB_LD: `RegWre`=1, `PCWre`=1, `PCSrc`=00, `WrRegDSrc`=1.
    - `RegDst`=10 for R-type, 01 for I-type and lw.
    - `DBDataSrc`=1 in sWB_LD.
- Static decodes are held through EXE/MEM/WB of the instruction:
  - `ALUSrcA`=1 for sll.
  - `ALUSrcB`=1 for addiu/andi/ori/slti/lw/sw.
  - `ExtSel`=0 for andi/ori, otherwise 1.
  - `ALUOp` per the op: addiu/lw/sw→000, andi→100, ori→011, slti→101.
- `PCWre` is asserted in exactly one cycle per instruction: the last one. It is never asserted in sHALT.

## Timing
- Reset: `RST`=1 forces state=sIF immediately, without waiting for a clock edge. While `RST` is high, all outputs are 0, including `IRWre`. On the first rising edge after `RST` falls, state stays sIF with `IRWre`=1.
- Cycles per instruction:
  - j/jr/jal: 2.
  - Branch: 3.
  - ALU ops: 4.
  - sw: 4.
  - lw: 5.
- `PCSrc` and `PCWre` are valid across the whole cycle. The PC captures them on the falling edge mid-cycle.
- Reset asserted mid-instruction: the instruction is abandoned. No write occurs after `RST` rises.

## Structure
- `cpu_pkg` holds:
  - opcode localparams;
  - the state enum (4-bit);
  - `PCSrc`, `RegDst` and `ALUOp` code constants.
- One sub-module, `control_decode`, holds the purely combinational opcode→static-decode logic. The top level holds the state register, next-state logic and per-state enables.

## Test plan
- RST=1 mid-sEXE_AL → state=sIF the same cycle and all outputs 0. After release, `IRWre`=1 in the first cycle.
- add (000000) → states IF, ID, EXE_AL, WB_AL. In the WB cycle: `RegWre`=1, `RegDst`=10, `PCWre`=1, `PCSrc`=00.
- lw (110001) → 5 cycles. `mRD`=1 in MEM. In WB: `DBDataSrc`=1, `RegDst`=01, `ALUSrcB`=1, `ExtSel`=1.
- beq with zero=1 → `PCSrc`=01 in EXE_BR. With zero=0 → `PCSrc`=00. bltz with sign=1 → 01.
- jal (111010) → 2 cycles. In ID: `PCSrc`=11, `PCWre`=1, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0.
- halt (111111) and undefined opcode 101010 → sHALT. `PCWre` stays 0 for 10 cycles and the state leaves sHALT only on RST.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU control path: opcodes, FSM states,
// opcode classes and the PCSrc / RegDst / ALUOp code points.
package cpu_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_EXE_BR = 4'd3,
      S_EXE_LS = 4'd4,
      S_MEM    = 4'd5,
      S_WB_AL  = 4'd6,
      S_WB_LD  = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      C_ALU  = 3'd0,
      C_MEM  = 3'd1,
      C_BR   = 3'd2,
      C_JMP  = 3'd3,
      C_HALT = 3'd4
   } op_class_t;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JR     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decode: instruction class plus the static
// datapath selects held for the whole EXE/MEM/WB portion of an instruction.
module control_decode
   import cpu_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_t  op_class,
   output logic       is_load,
   output logic       is_jr,
   output logic       is_jal,
   output logic       alu_src_a,
   output logic       alu_src_b,
   output logic       ext_sel,
   output logic [2:0] alu_op,
   output logic [1:0] wb_reg_dst
);

   always_comb begin
      op_class   = C_HALT;
      alu_op     = ALU_ADD;
      wb_reg_dst = RD_RT;
      case (opcode)
         OP_ADD:   begin op_class = C_ALU; alu_op = ALU_ADD; wb_reg_dst = RD_RD; end
         OP_SUB:   begin op_class = C_ALU; alu_op = ALU_SUB; wb_reg_dst = RD_RD; end
         OP_AND:   begin op_class = C_ALU; alu_op = ALU_AND; wb_reg_dst = RD_RD; end
         OP_SLL:   begin op_class = C_ALU; alu_op = ALU_SLL; wb_reg_dst = RD_RD; end
         OP_SLT:   begin op_class = C_ALU; alu_op = ALU_SLT; wb_reg_dst = RD_RD; end
         OP_ADDIU: begin op_class = C_ALU; alu_op = ALU_ADD; end
         OP_ANDI:  begin op_class = C_ALU; alu_op = ALU_AND; end
         OP_ORI:   begin op_class = C_ALU; alu_op = ALU_OR;  end
         OP_SLTI:  begin op_class = C_ALU; alu_op = ALU_SLT; end
         OP_SW, OP_LW:             op_class = C_MEM;
         OP_BEQ, OP_BNE, OP_BLTZ:  op_class = C_BR;
         OP_J, OP_JR, OP_JAL:      op_class = C_JMP;
         default:                  op_class = C_HALT;
      endcase
   end

   assign is_load   = (opcode == OP_LW);
   assign is_jr     = (opcode == OP_JR);
   assign is_jal    = (opcode == OP_JAL);
   assign alu_src_a = (opcode == OP_SLL);
   assign alu_src_b = (opcode == OP_ADDIU) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                      (opcode == OP_SLTI)  || (opcode == OP_LW)   || (opcode == OP_SW);
   assign ext_sel   = !((opcode == OP_ANDI) || (opcode == OP_ORI));

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM: steps each instruction through IF/ID/EXE/MEM/WB and
// drives PC write/source plus datapath enables combinationally from the state.
module multi_cycle_control
   import cpu_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       sign,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       IRWre,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic [2:0] ALUOp,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc
);

   state_t     state_reg, state_next;
   logic       start_reg;
   op_class_t  op_class;
   logic       is_load, is_jr, is_jal;
   logic       alu_src_a, alu_src_b, ext_sel;
   logic [2:0] alu_op;
   logic [1:0] wb_reg_dst;
   logic       use_static, br_taken;

   control_decode u_decode (
      .opcode     (opcode),
      .op_class   (op_class),
      .is_load    (is_load),
      .is_jr      (is_jr),
      .is_jal     (is_jal),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ext_sel    (ext_sel),
      .alu_op     (alu_op),
      .wb_reg_dst (wb_reg_dst)
   );

   // The first edge after reset release keeps the FSM in IF for one more cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= S_IF;
         start_reg <= 1'b1;
      end else begin
         start_reg <= 1'b0;
         state_reg <= start_reg ? S_IF : state_next;
      end
   end

   assign use_static = (state_reg == S_EXE_AL) || (state_reg == S_EXE_BR) ||
                       (state_reg == S_EXE_LS) || (state_reg == S_MEM) ||
                       (state_reg == S_WB_AL)  || (state_reg == S_WB_LD);

   assign br_taken = ((opcode == OP_BEQ)  &&  zero) ||
                     ((opcode == OP_BNE)  && !zero) ||
                     ((opcode == OP_BLTZ) &&  sign);

   always_comb begin
      state_next = state_reg;
      PCWre      = 1'b0;
      PCSrc      = PC_NEXT;
      IRWre      = 1'b0;
      RegWre     = 1'b0;
      RegDst     = RD_RA;
      WrRegDSrc  = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 1'b0;
      ExtSel     = 1'b0;
      ALUOp      = ALU_ADD;
      mRD        = 1'b0;
      mWR        = 1'b0;
      DBDataSrc  = 1'b0;

      if (use_static) begin
         ALUSrcA = alu_src_a;
         ALUSrcB = alu_src_b;
         ExtSel  = ext_sel;
         ALUOp   = alu_op;
      end

      case (state_reg)
         S_IF: begin
            IRWre      = 1'b1;
            state_next = S_ID;
         end
         S_ID: begin
            case (op_class)
               C_JMP: begin
                  PCWre      = 1'b1;
                  PCSrc      = is_jr ? PC_JR : PC_JUMP;
                  RegWre     = is_jal;
                  state_next = S_IF;
               end
               C_BR:    state_next = S_EXE_BR;
               C_MEM:   state_next = S_EXE_LS;
               C_ALU:   state_next = S_EXE_AL;
               default: state_next = S_HALT;
            endcase
         end
         S_EXE_AL: state_next = S_WB_AL;
         S_EXE_BR: begin
            PCWre      = 1'b1;
            ALUOp      = ALU_SUB;
            PCSrc      = br_taken ? PC_BRANCH : PC_NEXT;
            state_next = S_IF;
         end
         S_EXE_LS: state_next = S_MEM;
         S_MEM: begin
            if (is_load) begin
               mRD        = 1'b1;
               state_next = S_WB_LD;
            end else begin
               mWR        = 1'b1;
               PCWre      = 1'b1;
               state_next = S_IF;
            end
         end
         S_WB_AL, S_WB_LD: begin
            RegWre     = 1'b1;
            PCWre      = 1'b1;
            WrRegDSrc  = 1'b1;
            RegDst     = wb_reg_dst;
            DBDataSrc  = (state_reg == S_WB_LD);
            state_next = S_IF;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IF;
      endcase

      // Reset silences every enable, including the IF-state IRWre.
      if (RST) begin
         PCWre     = 1'b0;
         PCSrc     = PC_NEXT;
         IRWre     = 1'b0;
         RegWre    = 1'b0;
         RegDst    = RD_RA;
         WrRegDSrc = 1'b0;
         ALUSrcA   = 1'b0;
         ALUSrcB   = 1'b0;
         ExtSel    = 1'b0;
         ALUOp     = ALU_ADD;
         mRD       = 1'b0;
         mWR       = 1'b0;
         DBDataSrc = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench: directed and random instruction streams compared cycle by
// cycle against a per-instruction-phase reference model of the control outputs.
module tb_multi_cycle_control;

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] opcode;
   logic       zero, sign;
   logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
   logic       mRD, mWR, DBDataSrc;
   logic [1:0] PCSrc, RegDst;
   logic [2:0] ALUOp;

   int checks = 0;
   int errors = 0;

   multi_cycle_control dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
      .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
      .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD),
      .mWR(mWR), .DBDataSrc(DBDataSrc)
   );

   always #5 CLK = ~CLK;

   // {PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc}
   logic [16:0] obs;
   assign obs = {PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA,
                 ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc};

   function automatic int kind(input logic [5:0] op);
      // 0 alu, 1 mem, 2 branch, 3 jump, 4 halt
      case (op)
         6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
         6'b010010, 6'b011000, 6'b100110, 6'b100111: return 0;
         6'b110000, 6'b110001:                       return 1;
         6'b110100, 6'b110101, 6'b110110:            return 2;
         6'b111000, 6'b111001, 6'b111010:            return 3;
         default:                                    return 4;
      endcase
   endfunction

   function automatic int n_cycles(input logic [5:0] op);
      case (kind(op))
         0: return 4;
         1: return (op == 6'b110001) ? 5 : 4;
         2: return 3;
         3: return 2;
         default: return 12;
      endcase
   endfunction

   // Expected outputs in cycle k (0 = fetch) of an instruction with opcode op.
   function automatic logic [16:0] exp_out(input logic [5:0] op, input int k,
                                           input logic z, input logic s);
      logic       pcwre = 0, irwre = 0, regwre = 0, wrsrc = 0;
      logic       asa = 0, asb = 0, ext = 0, mrd = 0, mwr = 0, dbsrc = 0;
      logic [1:0] pcsrc = 2'b00, regdst = 2'b00;
      logic [2:0] aluop = 3'b000;
      logic       is_lw = (op == 6'b110001);
      logic       itype = (op == 6'b000010) || (op == 6'b010001) ||
                          (op == 6'b010010) || (op == 6'b100111);
      int         kd = kind(op);
      int         last = n_cycles(op) - 1;
      if (k == 0) irwre = 1;
      else if (k == 1) begin
         if (kd == 3) begin
            pcwre = 1;
            pcsrc = (op == 6'b111001) ? 2'b10 : 2'b11;
            regwre = (op == 6'b111010);
         end
      end else if (kd != 4) begin
         asa = (op == 6'b011000);
         asb = itype || kd == 1;
         ext = !(op == 6'b010001 || op == 6'b010010);
         case (op)
            6'b000001:            aluop = 3'b001;
            6'b010000, 6'b010001: aluop = 3'b100;
            6'b010010:            aluop = 3'b011;
            6'b011000:            aluop = 3'b010;
            6'b100110, 6'b100111: aluop = 3'b101;
            default:              aluop = 3'b000;
         endcase
         if (kd == 2) begin
            aluop = 3'b001;
            pcwre = 1;
            if ((op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s))
               pcsrc = 2'b01;
         end else if (kd == 1 && k == 3) begin
            mrd = is_lw;
            mwr = !is_lw;
            pcwre = !is_lw;
         end else if (k == last) begin
            regwre = 1; pcwre = 1; wrsrc = 1;
            regdst = (kd == 1 || itype) ? 2'b01 : 2'b10;
            dbsrc = is_lw;
         end
      end
      return {pcwre, pcsrc, irwre, regwre, regdst, wrsrc, asa, asb, ext, aluop, mrd, mwr, dbsrc};
   endfunction

   task automatic check(input logic [16:0] e, input string tag, input int k);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, e);
      end
   endtask

   // Runs n cycles of one instruction starting at posedge+1 in IF; zf/sf < 0 means random.
   task automatic run_instr(input logic [5:0] op, input int n, input int zf,
                            input int sf, input string tag);
      opcode = op;
      for (int k = 0; k < n; k++) begin
         zero = (zf < 0) ? 1'($urandom_range(0, 1)) : (zf != 0);
         sign = (sf < 0) ? 1'($urandom_range(0, 1)) : (sf != 0);
         #3;
         check(exp_out(op, k, zero, sign), tag, k);
         @(posedge CLK); #1;
      end
      $display("instr %s op=%b cycles=%0d", tag, op, n);
   endtask

   // Asserts RST mid-cycle, checks silence, releases at a falling edge.
   task automatic pulse_reset(input string tag);
      #1 RST = 1'b1;
      #1 check(17'h0, {tag, "_async"}, 0);
      @(posedge CLK); #1;
      check(17'h0, {tag, "_held"}, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1 check(exp_out(6'b000000, 0, 1'b0, 1'b0), {tag, "_release"}, 0);
      @(posedge CLK); #1;
      $display("reset %s", tag);
   endtask

   logic [5:0] ops [16] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                            6'b010001, 6'b010010, 6'b011000, 6'b100110,
                            6'b100111, 6'b110000, 6'b110001, 6'b110100,
                            6'b110101, 6'b110110, 6'b111000, 6'b111001};

   initial begin
      RST = 1'b1; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
      #1 check(17'h0, "reset_out", 0);
      repeat (2) @(posedge CLK);
      #1 check(17'h0, "reset_hold", 0);
      @(negedge CLK);
      RST = 1'b0;
      #1 check(exp_out(6'b000000, 0, 1'b0, 1'b0), "first_if_pre", 0);
      @(posedge CLK); #1;

      run_instr(6'b000000, 4, -1, -1, "add");
      run_instr(6'b110001, 5, -1, -1, "lw");
      run_instr(6'b110000, 4, -1, -1, "sw");
      run_instr(6'b110100, 3, 1, -1, "beq_taken");
      run_instr(6'b110100, 3, 0, -1, "beq_not");
      run_instr(6'b110101, 3, 0, -1, "bne_taken");
      run_instr(6'b110110, 3, -1, 1, "bltz_taken");
      run_instr(6'b110110, 3, -1, 0, "bltz_not");
      run_instr(6'b111010, 2, -1, -1, "jal");
      run_instr(6'b111001, 2, -1, -1, "jr");
      run_instr(6'b010010, 4, -1, -1, "ori");

      run_instr(6'b000000, 2, -1, -1, "add_abort");
      pulse_reset("mid_exe_al");

      for (int i = 0; i < 40; i++) begin
         logic [5:0] op = ops[$urandom_range(0, 15)];
         run_instr(op, n_cycles(op), -1, -1, "rand");
      end

      run_instr(6'b111111, 12, -1, -1, "halt");
      pulse_reset("leave_halt");
      run_instr(6'b101010, 12, -1, -1, "undef_halt");
      pulse_reset("leave_undef");
      run_instr(6'b000010, 4, -1, -1, "addiu_after_halt");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
